// File: rtl/imem_load_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : imem_load_run_ctrl
// Purpose : clears the core, streams a program into its IMEM, releases reset,
//           and gates run_pc for a budget. Optional: IMEM_LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
module imem_load_run_ctrl #(
  parameter int ADDR_W = 8,
  parameter int RUN_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  input  logic [RUN_W-1:0]  run_cycles,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              instruction_write,
  output logic [ADDR_W-1:0] instruction_addr,
  output logic [31:0]       instruction_data,
  output logic              core_reset_n,
  output logic              run_pc,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] c_depth = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_FLUSH = 3'd3,
    S_RUN   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_clr_phase;
  logic [ADDR_W:0]     r_count;
  logic [ADDR_W:0]     r_accepted;
  logic [ADDR_W-1:0]   r_addr;
  logic [RUN_W-1:0]    r_budget;
  logic [RUN_W-1:0]    r_run_cnt;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic                r_core_reset_n;
  logic                r_run_pc;
  logic                r_busy;
  logic                r_done;
  logic                w_launch;
  logic                w_accept;
  logic                w_last;

  assign s_ready  = (r_state == S_LOAD) && (r_accepted < r_count);
  // A beat offered in the abort cycle is dropped together with any strobe.
  assign w_accept = s_valid && s_ready && !abort;
  assign w_last   = ((r_accepted + (ADDR_W+1)'(1)) == r_count);
  assign w_launch = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CLEAR;
      S_CLEAR: if (r_clr_phase) w_next = (r_count == '0) ? S_FLUSH : S_LOAD;
      S_LOAD:  if (w_accept && w_last) w_next = S_FLUSH;
      S_FLUSH: w_next = S_RUN;
      S_RUN:   if ((r_budget != '0) && (r_run_cnt == RUN_W'(1))) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_CLEAR;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Status outputs are registered from the next state so they move with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_core_reset_n <= 1'b0;
      r_run_pc       <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_core_reset_n <= (w_next == S_RUN) || (w_next == S_DONE);
      r_run_pc       <= (w_next == S_RUN);
      r_busy         <= (w_next == S_CLEAR) || (w_next == S_LOAD) ||
                        (w_next == S_FLUSH) || (w_next == S_RUN);
      r_done         <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_phase <= 1'b0;
      r_count     <= '0;
      r_accepted  <= '0;
      r_addr      <= '0;
      r_budget    <= '0;
      r_run_cnt   <= '0;
      r_wr        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
    end else begin
      r_wr <= w_accept;
      if (w_accept) begin
        r_waddr    <= r_addr;
        r_wdata    <= s_data;
        r_addr     <= r_addr + ADDR_W'(1);
        r_accepted <= r_accepted + (ADDR_W+1)'(1);
      end
      if (w_launch) begin
        r_count     <= (word_count > c_depth) ? c_depth : word_count;
        r_budget    <= run_cycles;
        r_addr      <= '0;
        r_accepted  <= '0;
        r_clr_phase <= 1'b0;
      end else if (r_state == S_CLEAR) begin
        r_clr_phase <= 1'b1;
      end
      if ((r_state == S_FLUSH) && (w_next == S_RUN)) begin
        r_run_cnt <= r_budget;
      end else if ((r_state == S_RUN) && (r_run_cnt != '0)) begin
        r_run_cnt <= r_run_cnt - RUN_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] r_sum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum <= '0;
    end else if (w_launch) begin
      r_sum <= '0;
    end else if (w_accept) begin
      r_sum <= r_sum + s_data;
    end
  end

  assign checksum = r_sum;
`else
  assign checksum = 32'd0;
`endif

  assign instruction_write = r_wr;
  assign instruction_addr  = r_waddr;
  assign instruction_data  = r_wdata;
  assign core_reset_n      = r_core_reset_n;
  assign run_pc            = r_run_pc;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule
`default_nettype wire

// File: tb/tb_imem_load_run_ctrl.sv
`default_nettype none
// Bench for imem_load_run_ctrl: timeline reference model plus per-cycle compare.
module tb_imem_load_run_ctrl;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [8:0]  word_count = '0;
  logic [15:0] run_cycles = '0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready;
  logic        instruction_write;
  logic [7:0]  instruction_addr;
  logic [31:0] instruction_data;
  logic        core_reset_n;
  logic        run_pc;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  imem_load_run_ctrl #(.ADDR_W(8), .RUN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .word_count(word_count), .run_cycles(run_cycles),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .instruction_write(instruction_write), .instruction_addr(instruction_addr),
    .instruction_data(instruction_data), .core_reset_n(core_reset_n),
    .run_pc(run_pc), .busy(busy), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is described by its start edge, the edge of
  // its last accept and the derived RUN entry edge; outputs follow from those.
  int          e = 0;
  int          m_e0, m_erun, m_acc, m_cnt, m_bud;
  bit          m_seq = 0, m_run_known = 0, m_isdone = 0;
  bit          m_rdy = 0, m_run = 0, m_core = 0, m_busy = 0, m_wr = 0;
  logic [7:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [31:0] m_sum = '0;

  always @(posedge clk) begin
    e++;
    m_wr = 0;
    if (!reset_n) begin
      m_seq = 0;
      m_sum = 0;
    end else if (abort) begin
      m_seq = 0;
    end else if (start && (!m_seq || m_isdone)) begin
      m_seq = 1;
      m_e0  = e;
      m_cnt = (int'(word_count) > DEPTH) ? DEPTH : int'(word_count);
      m_bud = int'(run_cycles);
      m_acc = 0;
      m_sum = 0;
      m_run_known = (m_cnt == 0);
      m_erun = e + 3;
    end else if (m_seq && m_rdy && s_valid) begin
      m_wr   = 1;
      m_addr = 8'(m_acc % DEPTH);
      m_data = s_data;
      m_sum  = m_sum + s_data;
      m_acc++;
      if (m_acc == m_cnt) begin
        m_run_known = 1;
        m_erun = e + 1;
      end
    end
    if (!reset_n || !m_seq) begin
      m_rdy = 0; m_run = 0; m_isdone = 0; m_core = 0; m_busy = 0;
    end else begin
      m_rdy    = (e >= m_e0 + 2) && (m_acc < m_cnt);
      m_run    = m_run_known && (e >= m_erun) && ((m_bud == 0) || (e < m_erun + m_bud));
      m_isdone = m_run_known && (m_bud != 0) && (e >= m_erun + m_bud);
      m_core   = m_run_known && (e >= m_erun);
      m_busy   = !m_isdone;
    end
  end

  // Observers used by the directed literal checks.
  int         n_wr = 0, n_run = 0, n_rdy = 0;
  logic [7:0] last_addr = '0;

  task automatic clr_obs();
    n_wr = 0; n_run = 0; n_rdy = 0; last_addr = '0;
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_sum;
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_sum = m_sum;
`else
    exp_sum = 32'd0;
`endif
    if (!reset_n) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_write", instruction_write, 0);
      chk("rst_addr", instruction_addr, 0);
      chk("rst_data", instruction_data, 0);
      chk("rst_core_reset_n", core_reset_n, 0);
      chk("rst_run_pc", run_pc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_checksum", checksum, 0);
    end else begin
      chk("s_ready", s_ready, m_rdy);
      chk("instruction_write", instruction_write, m_wr);
      if (m_wr) begin
        chk("instruction_addr", instruction_addr, m_addr);
        chk("instruction_data", instruction_data, m_data);
      end
      chk("core_reset_n", core_reset_n, m_core);
      chk("run_pc", run_pc, m_run);
      chk("busy", busy, m_seq && m_busy);
      chk("done", done, m_seq && m_isdone);
      chk("checksum", checksum, exp_sum);
    end
    if (instruction_write) begin
      n_wr++;
      last_addr = instruction_addr;
    end
    if (run_pc)  n_run++;
    if (s_ready) n_rdy++;
  end

  logic [31:0] words [0:511];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int c, input int n, input int vprob, input bit alt,
                         input bit noise, input int max_cyc);
    int idx;
    bit acc;
    idx = 0;
    clr_obs();
    word_count = 9'(c);
    run_cycles = 16'(n);
    start = 1'b1;
    s_valid = 1'b0;
    s_data = words[0];
    tick();
    start = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (done) begin
        start = 1'b0;
        break;
      end
      tick();
      if (acc) idx++;
      s_valid = alt ? !s_valid : ($urandom_range(0, 99) < vprob);
      s_data  = words[idx];
      start   = noise && ($urandom_range(0, 9) == 0);
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("seq_reached_done", done, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    bit acc;
    int idx;
    for (int i = 0; i < 512; i++) words[i] = $urandom;
    #1 reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_core_reset_n", core_reset_n, 0);
    chk("reset_s_ready", s_ready, 0);
    chk("reset_checksum", checksum, 0);

    // Basic load and run
    words[0] = 32'h00500093; words[1] = 32'h00108113; words[2] = 32'h002081B3;
    run_seq(3, 5, 100, 0, 0, 100);
    chk("basic_writes", n_wr, 3);
    chk("basic_last_addr", last_addr, 2);
    chk("basic_run_cycles", n_run, 5);
    chk("basic_done", done, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("basic_checksum", checksum, 32'h00810359);  // 0x00500093+0x00108113+0x002081B3
`else
    chk("basic_checksum", checksum, 32'h0);
`endif

    // Gapped source
    run_seq(2, 4, 0, 1, 0, 100);
    chk("gap_writes", n_wr, 2);
    chk("gap_last_addr", last_addr, 1);

    // Zero count
    run_seq(0, 3, 100, 0, 0, 50);
    chk("zero_writes", n_wr, 0);
    chk("zero_ready", n_rdy, 0);
    chk("zero_run_cycles", n_run, 3);

    // Full depth with clipping
    run_seq(300, 2, 100, 0, 0, 400);
    chk("full_writes", n_wr, 256);
    chk("full_last_addr", last_addr, 255);
    chk("full_ready_cycles", n_rdy, 256);

    // Randomized sequences with start noise while busy
    for (int r = 0; r < 10; r++) begin
      run_seq($urandom_range(0, 40), $urandom_range(1, 10),
              $urandom_range(20, 100), 0, 1, 400);
    end

    // Abort during LOAD after 2 of 4 accepts, start in the same cycle
    clr_obs();
    word_count = 9'd4; run_cycles = 16'd3; start = 1'b1;
    tick();
    start = 1'b0; s_valid = 1'b1; s_data = words[0];
    idx = 0; k = 0;
    while (idx < 2 && k < 50) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      tick();
      if (acc) begin
        idx++;
        s_data = words[idx];
      end
      k++;
    end
    chk("abort_two_accepts", idx, 2);
    s_valid = 1'b0; abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_core_reset_n", core_reset_n, 0);
    chk("abort_write", instruction_write, 0);
    tick();
    chk("abort_start_ignored", busy, 0);

    // Abort in RUN with budget 0
    word_count = 9'd0; run_cycles = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (!run_pc && k < 20) begin tick(); k++; end
    repeat (3) tick();
    chk("run0_still_running", run_pc, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("run0_abort_run_pc", run_pc, 0);
    chk("run0_abort_busy", busy, 0);

    // Asynchronous reset in RUN
    word_count = 9'd1; run_cycles = 16'd0; start = 1'b1;
    tick();
    start = 1'b0; s_valid = 1'b1; s_data = words[5];
    k = 0;
    while (!run_pc && k < 20) begin tick(); k++; end
    s_valid = 1'b0;
    chk("areset_running", run_pc, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_run_pc", run_pc, 0);
    chk("areset_busy", busy, 0);
    chk("areset_core_reset_n", core_reset_n, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
